add_comp_datapath: RTL and testbench

- Datapath partner of the ADD/COMP/SMALL/LARGE control-unit FSM.
- Accepts an operand pair over a valid/ready handshake.
- On the control unit's write strobe (we=1, s=0) it registers the sum.
- During the control unit's compare cycle (s=1, we=0) it presents the comparison flag x, which the control unit samples combinationally to pick SMALL or LARGE.
- Keeps overflow, error and operation-count status for the surrounding processor.

---
 rtl/add_comp_datapath_if.sv | 28 ++
 rtl/add_comp_datapath.sv | 110 +++++++++++
 tb/tb_add_comp_datapath.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/add_comp_datapath_if.sv
// Operand/strobe/status bundle between a control unit (master) and add_comp_datapath (slave).
interface add_comp_datapath_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             we;
  logic             s;
  logic             x;
  logic [WIDTH-1:0] sum_q;
  logic             ovf;
  logic             last_small;
  logic             err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, we, s,
    input  in_ready, x, sum_q, ovf, last_small, err, op_count
  );

  modport slave (
    input  in_valid, a, b, we, s,
    output in_ready, x, sum_q, ovf, last_small, err, op_count
  );
endinterface

// File: rtl/add_comp_datapath.sv
// Add/compare datapath: latches an operand pair, sums it on the write strobe and
// exposes a "sum < THRESH" flag during the compare phase.
module add_comp_datapath #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned THRESH = 100,
  parameter int unsigned CNT_W  = 8
) (
  input logic                CLK,
  input logic                reset,
  add_comp_datapath_if.slave bus
);

  localparam logic [WIDTH-1:0] Thresh = WIDTH'(THRESH);

  typedef enum logic [1:0] {StIdle, StLoaded, StSummed} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_reg_q, sum_reg_d;
  logic             ovf_q, ovf_d;
  logic             last_small_q, last_small_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [WIDTH:0]   add_full;
  logic             x;
  logic             proto_err;

  assign add_full = {1'b0, a_q} + {1'b0, b_q};

  // Overflowed sums count as large regardless of their truncated value.
  assign x = (state_q == StSummed) && !ovf_q && (sum_reg_q < Thresh);

  assign proto_err = (bus.we && bus.s)
                   || (bus.we && (state_q != StLoaded))
                   || (bus.s && !bus.we && (state_q != StSummed));

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_reg_d    = sum_reg_q;
    ovf_d        = ovf_q;
    last_small_d = last_small_q;
    err_d        = err_q;
    op_count_d   = op_count_q;

    // A bad strobe only raises err; it never advances the datapath.
    if (proto_err) begin
      err_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_d     = bus.a;
            b_d     = bus.b;
            state_d = StLoaded;
          end
        end
        StLoaded: begin
          if (bus.we && !bus.s) begin
            sum_reg_d = add_full[WIDTH-1:0];
            ovf_d     = add_full[WIDTH];
            state_d   = StSummed;
          end
        end
        StSummed: begin
          if (bus.s && !bus.we) begin
            last_small_d = x;
            op_count_d   = op_count_q + CNT_W'(1);
            state_d      = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      sum_reg_q    <= '0;
      ovf_q        <= 1'b0;
      last_small_q <= 1'b0;
      err_q        <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_reg_q    <= sum_reg_d;
      ovf_q        <= ovf_d;
      last_small_q <= last_small_d;
      err_q        <= err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.x          = x;
  assign bus.sum_q      = sum_reg_q;
  assign bus.ovf        = ovf_q;
  assign bus.last_small = last_small_q;
  assign bus.err        = err_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_add_comp_datapath.sv
// Directed bench for add_comp_datapath with hand-computed expectations.
module tb_add_comp_datapath;

  logic CLK = 1'b0;
  logic reset;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  add_comp_datapath_if #(.WIDTH(8), .CNT_W(8)) bus ();

  add_comp_datapath #(
    .WIDTH (8),
    .THRESH(100),
    .CNT_W (8)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] av, input logic [7:0] bv);
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic write_strobe();
    bus.we = 1'b1;
    step();
    bus.we = 1'b0;
  endtask

  task automatic compare_strobe();
    bus.s = 1'b1;
    step();
    bus.s = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.we       = 1'b0;
    bus.s        = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_sum", bus.sum_q, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_err", bus.err, 0);
    check("rst_cnt", bus.op_count, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_x", bus.x, 0);
    check("rst_last", bus.last_small, 0);

    // 30 + 40 = 70 < 100
    load(8'd30, 8'd40);
    check("t1_ready_loaded", bus.in_ready, 0);
    check("t1_x_loaded", bus.x, 0);
    write_strobe();
    check("t1_sum", bus.sum_q, 70);
    check("t1_ovf", bus.ovf, 0);
    check("t1_x_summed", bus.x, 1);
    step();
    check("t1_x_hold", bus.x, 1);
    check("t1_ready_summed", bus.in_ready, 0);
    compare_strobe();
    check("t1_last", bus.last_small, 1);
    check("t1_cnt", bus.op_count, 1);
    check("t1_ready_idle", bus.in_ready, 1);
    check("t1_x_idle", bus.x, 0);

    // 60 + 40 = 100, equality is not small
    load(8'd60, 8'd40);
    write_strobe();
    check("t2_sum", bus.sum_q, 100);
    check("t2_x", bus.x, 0);
    compare_strobe();
    check("t2_last", bus.last_small, 0);
    check("t2_cnt", bus.op_count, 2);

    // 200 + 100 = 300 -> 44 with carry; overflow forces large
    load(8'd200, 8'd100);
    write_strobe();
    check("t3_sum", bus.sum_q, 44);
    check("t3_ovf", bus.ovf, 1);
    check("t3_x", bus.x, 0);
    compare_strobe();
    check("t3_last", bus.last_small, 0);
    check("t3_cnt", bus.op_count, 3);

    // in_valid while LOADED is ignored
    load(8'd10, 8'd20);
    load(8'd90, 8'd90);
    write_strobe();
    check("t4_sum", bus.sum_q, 30);
    check("t4_ovf", bus.ovf, 0);
    check("t4_err", bus.err, 0);
    compare_strobe();
    check("t4_last", bus.last_small, 1);
    check("t4_cnt", bus.op_count, 4);

    // reset while SUMMED
    load(8'd30, 8'd40);
    write_strobe();
    check("t5_sum_pre", bus.sum_q, 70);
    do_reset();
    check("t5_sum", bus.sum_q, 0);
    check("t5_ovf", bus.ovf, 0);
    check("t5_cnt", bus.op_count, 0);
    check("t5_x", bus.x, 0);
    check("t5_ready", bus.in_ready, 1);

    // we in IDLE is an error and changes nothing else
    write_strobe();
    check("t6_err", bus.err, 1);
    check("t6_sum", bus.sum_q, 0);
    check("t6_ready", bus.in_ready, 1);

    // s in LOADED is an error and keeps the state
    load(8'd5, 8'd6);
    compare_strobe();
    check("t6_err_loaded", bus.err, 1);
    check("t6_ready_loaded", bus.in_ready, 0);
    check("t6_cnt_loaded", bus.op_count, 0);
    write_strobe();
    check("t6_sum_after", bus.sum_q, 11);
    compare_strobe();
    check("t6_cnt_1", bus.op_count, 1);

    // 255 more ops: 1 + 255 = 256 wraps to 0
    for (int i = 0; i < 254; i++) begin
      load(8'd1, 8'd2);
      write_strobe();
      compare_strobe();
    end
    check("t6_cnt_255", bus.op_count, 255);
    load(8'd1, 8'd2);
    write_strobe();
    compare_strobe();
    check("t6_cnt_wrap", bus.op_count, 0);
    check("t6_err_sticky", bus.err, 1);
    check("t6_sum_last", bus.sum_q, 3);
    check("t6_last", bus.last_small, 1);

    do_reset();
    check("t6_err_clr", bus.err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
